// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
// Holds the FSM state encoding, the buffered fetch entry and the PC legality test.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int ADDR_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
    } fetch_entry_t;

    // A PC is fetchable only when word aligned and inside the memory image.
    function automatic logic pc_is_legal(input logic [ADDR_W-1:0] pc,
                                         input int unsigned       words);
        logic [ADDR_W-1:0] limit;
        limit = ADDR_W'(words) * ADDR_W'(INSTR_BYTES);
        return (pc[1:0] == 2'b00) && (pc < limit);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer with wrap-bit pointers; flush wins over push.
// The head is read from registered slots and forced to zero when empty.
module fetch_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [63:0]
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t entry,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_reg;
    logic [PTR_W:0] rd_ptr_reg;
    entry_t         slots [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_pop  = pop && !flush && !empty;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + {{PTR_W{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            entry_t slot_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (do_push && (wr_ptr_reg[PTR_W-1:0] == PTR_W'(gi))) begin
                    slot_reg <= entry;
                end
            end

            assign slots[gi] = slot_reg;
        end
    endgenerate

    always_comb begin
        head = '0;
        if (!empty) begin
            head = slots[rd_ptr_reg[PTR_W-1:0]];
        end
    end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Owns the PC, walks the combinational instruction memory and buffers words for decode.
// Handles start/halt sequencing, branch redirects and the sticky fetch error.
module imem_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        busy,
    output logic        fetch_err
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic         err_reg;

    logic         pc_legal;
    logic         redirect_legal;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         flush;
    logic         fetch_en;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign pc_legal       = pc_is_legal(pc_reg, IMEM_WORDS);
    assign redirect_legal = pc_is_legal(redirect_pc, IMEM_WORDS);

    assign pop      = if_valid && id_ready;
    assign flush    = redirect_valid && (state_reg != IDLE);
    assign fetch_en = (state_reg == RUN) && !halt_req && pc_legal &&
                      (!fifo_full || pop) && !redirect_valid;

    assign push_entry.pc    = pc_reg;
    assign push_entry.instr = imem_instr;

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fetch_en),
        .pop   (pop),
        .flush (flush),
        .entry (push_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_entry)
    );

    // A redirect replaces the PC in every active state; what happens to the
    // state itself depends on where we are and whether an error is latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        pc_reg    <= RESET_PC;
                    end
                end
                RUN: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_pc;
                    end else if (!pc_legal) begin
                        err_reg   <= 1'b1;
                        state_reg <= DRAIN;
                    end else if (halt_req) begin
                        state_reg <= DRAIN;
                    end else if (fetch_en) begin
                        pc_reg <= pc_reg + 32'd4;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_pc;
                    end
                    if (fifo_empty) begin
                        state_reg <= HALT;
                    end
                end
                HALT: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_pc;
                    end
                    if (!err_reg && (start || (redirect_valid && redirect_legal))) begin
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign imem_addr = pc_reg;
    assign if_valid  = !fifo_empty;
    assign if_pc     = head_entry.pc;
    assign if_instr  = head_entry.instr;
    assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign fetch_err = err_reg;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Randomized and directed checks of the fetch sequencer against a queue-based model.
// The bench owns the instruction memory image and drives imem_instr from imem_addr.
module tb_imem_fetch_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_WORDS = 64;
    localparam int          DEPTH      = 2;
    localparam int          M_IDLE     = 0;
    localparam int          M_RUN      = 1;
    localparam int          M_DRAIN    = 2;
    localparam int          M_HALT     = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
    logic        busy;
    logic        fetch_err;

    logic [31:0] imem [IMEM_WORDS];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural state only.
    int          m_st;
    logic [31:0] m_pc;
    logic        m_err;
    logic [63:0] m_q [$];

    always #5 clk = ~clk;

    assign imem_instr = imem[imem_addr[7:2]];

    imem_fetch_sequencer #(
        .RESET_PC   (RESET_PC),
        .IMEM_WORDS (IMEM_WORDS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .busy           (busy),
        .fetch_err      (fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] p);
        return (p[1:0] == 2'b00) && (p < 32'(IMEM_WORDS * 4));
    endfunction

    task automatic m_reset();
        m_st  = M_IDLE;
        m_pc  = RESET_PC;
        m_err = 1'b0;
        m_q.delete();
    endtask

    // One clock edge of the specified behaviour, evaluated on the current inputs.
    task automatic model_step();
        bit          was_empty;
        bit          pop;
        bit          fe;
        bit          redir;
        logic [31:0] cur_pc;
        was_empty = (m_q.size() == 0);
        pop       = !was_empty && id_ready;
        redir     = redirect_valid && (m_st != M_IDLE);
        cur_pc    = m_pc;
        fe = (m_st == M_RUN) && !halt_req && legal(cur_pc) &&
             ((m_q.size() < DEPTH) || pop) && !redirect_valid;

        if (redir) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (fe) m_q.push_back({cur_pc, imem[cur_pc[7:2]]});
        end

        if (redir)                             m_pc = redirect_pc;
        else if (m_st == M_IDLE && start)      m_pc = RESET_PC;
        else if (fe)                           m_pc = cur_pc + 32'd4;

        if (m_st == M_RUN && !redirect_valid && !legal(cur_pc)) m_err = 1'b1;

        case (m_st)
            M_IDLE:  if (start) m_st = M_RUN;
            M_RUN:   if (!redirect_valid && (halt_req || !legal(cur_pc))) m_st = M_DRAIN;
            M_DRAIN: if (was_empty) m_st = M_HALT;
            default: if (!m_err && (start || (redirect_valid && legal(redirect_pc)))) m_st = M_RUN;
        endcase
    endtask

    task automatic check_outputs();
        logic [63:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 64'd0;
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_q.size() > 0));
        chk("if_pc", if_pc, h[63:32]);
        chk("if_instr", if_instr, h[31:0]);
        chk("busy", 32'(busy), 32'(m_st == M_RUN || m_st == M_DRAIN));
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
    endtask

    task automatic step(input logic s, input logic h, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        start          = s;
        halt_req       = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Asserts reset between edges so the asynchronous clear is observed directly.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        start          = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        #1;
        m_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc;
        int          r;
        bit          hold_halt;

        for (int i = 0; i < IMEM_WORDS; i++) imem[i] = $urandom;
        imem[0] = 32'h2010_0004;
        imem[1] = 32'h2008_0001;
        m_reset();

        // Start latency and sequential fetch.
        do_reset();
        step(1, 0, 0, 0, 1);
        chk("lat_e0_valid", 32'(if_valid), 32'd0);
        step(0, 0, 0, 0, 1);
        chk("lat_e1_valid", 32'(if_valid), 32'd1);
        chk("seq_pc0", if_pc, 32'h0);
        chk("seq_instr0", if_instr, 32'h2010_0004);
        step(0, 0, 0, 0, 1);
        chk("seq_pc4", if_pc, 32'h4);
        chk("seq_instr4", if_instr, 32'h2008_0001);
        step(0, 0, 0, 0, 1);
        chk("seq_pc8", if_pc, 32'h8);

        // Decode stall fills the buffer and freezes the PC.
        do_reset();
        step(1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_head", if_pc, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("stall_head4", if_pc, 32'h4);
        step(0, 0, 0, 0, 1);
        chk("stall_head8", if_pc, 32'h8);

        // Redirect while full.
        do_reset();
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h34, 0);
        chk("redir_flush", 32'(if_valid), 32'd0);
        step(0, 0, 0, 0, 1);
        chk("redir_head", if_pc, 32'h34);
        step(0, 0, 0, 0, 1);
        chk("redir_next", if_pc, 32'h38);

        // Halt with two entries buffered, then resume.
        do_reset();
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0, 1);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_pc", imem_addr, 32'h8);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("resume_pc", if_pc, 32'h8);

        // Misaligned and out-of-range redirect targets.
        for (int k = 0; k < 2; k++) begin
            rpc = (k == 0) ? 32'h2 : 32'h100;
            do_reset();
            step(1, 0, 0, 0, 1);
            step(0, 0, 0, 0, 1);
            step(0, 0, 1, rpc, 1);
            step(0, 0, 0, 0, 1);
            chk("err_set", 32'(fetch_err), 32'd1);
            chk("err_nopush", 32'(if_valid), 32'd0);
            repeat (2) step(0, 0, 0, 0, 1);
            step(1, 0, 0, 0, 1);
            step(0, 0, 0, 0, 1);
            chk("err_sticky", 32'(fetch_err), 32'd1);
            chk("err_halted", 32'(busy), 32'd0);
        end

        // Reset mid-run with a full buffer.
        do_reset();
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        do_reset();
        chk("rst_valid", 32'(if_valid), 32'd0);
        step(0, 0, 0, 0, 1);
        chk("rst_pc", imem_addr, 32'h0);

        // Randomized traffic with periodic resets.
        hold_halt = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                do_reset();
                step(1, 0, 0, 0, 1);
            end
            if ($urandom_range(0, 9) == 0) hold_halt = !hold_halt;
            r = $urandom_range(0, 63);
            if (r == 0)      rpc = 32'h2;
            else if (r == 1) rpc = 32'h100;
            else if (r == 2) rpc = $urandom;
            else             rpc = 32'($urandom_range(0, IMEM_WORDS - 1)) << 2;
            step($urandom_range(0, 15) == 0, hold_halt,
                 $urandom_range(0, 9) == 0, rpc, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
